// File: rtl/snoop_bus.sv
`default_nettype none
// ============================================================================
// snoop_bus: bus commands, snoop FSM states and address field helpers.
// Revision: 1.0
// ============================================================================
package snoop_bus;

  typedef enum logic [1:0] {
    BUS_READ       = 2'd0,
    BUS_WRITE      = 2'd1,
    BUS_INVALIDATE = 2'd2
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    FLUSH_READ = 3'd2,
    FLUSH_SEND = 3'd3,
    UPDATE     = 3'd4,
    RESPOND    = 3'd5,
    RELEASE    = 3'd6
  } snoop_state_t;

  // Callers zero-extend the address to 64 bits and cast the result down.
  function automatic logic [63:0] addr_tag(logic [63:0] addr, int unsigned ow, int unsigned iw);
    return addr >> (ow + iw);
  endfunction

  function automatic logic [63:0] addr_index(logic [63:0] addr, int unsigned ow, int unsigned iw);
    return (addr >> ow) & ((64'd1 << iw) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_offset(logic [63:0] addr, int unsigned ow);
    return addr & ((64'd1 << ow) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/states.sv
`default_nettype none
// ============================================================================
// states: per-line coherence state encoding shared by CPU and snoop sides.
// Revision: 1.0
// ============================================================================
package states;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    VALID   = 2'd1,
    DIRTY   = 2'd2
  } line_state_t;

endpackage
`default_nettype wire

// File: rtl/wti_flush_unit.sv
`default_nettype none
// ============================================================================
// wti_flush_unit: word counter and read/offer sequencing for a DIRTY flush.
// Revision: 1.0
// ============================================================================
module wti_flush_unit #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int INDEX_WIDTH   = 4,
  parameter int OFFSET_WIDTH  = 2,
  parameter int DATA_WIDTH    = 32,
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            read_phase,
  input  logic                            send_phase,
  input  logic [TAG_WIDTH-1:0]            tag,
  input  logic [INDEX_WIDTH-1:0]          index,
  input  logic [DATA_WIDTH-1:0]           dataIn,
  input  logic                            flushReady,
  output logic                            dataReadEnable,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] dataAddress,
  output logic                            flushValid,
  output logic [ADDRESS_WIDTH-1:0]        flushAddress,
  output logic [DATA_WIDTH-1:0]           flushData,
  output logic                            done
);

  logic [OFFSET_WIDTH-1:0] word;
  logic                    first_send;
  logic [DATA_WIDTH-1:0]   held_data;
  logic                    last_word;

  assign last_word = &word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word       <= '0;
      first_send <= 1'b0;
      held_data  <= '0;
    end else begin
      first_send <= read_phase;
      if (first_send) held_data <= dataIn;
      if (start) begin
        word <= '0;
      end else if (send_phase && flushReady && !last_word) begin
        word <= word + OFFSET_WIDTH'(1);
      end
    end
  end

  // RAM data is only valid in the first offer cycle; afterwards the held copy keeps it stable.
  always_comb begin
    dataReadEnable = read_phase;
    dataAddress    = read_phase ? {index, word} : '0;
    flushValid     = send_phase;
    flushAddress   = send_phase ? {tag, index, word} : '0;
    flushData      = send_phase ? (first_send ? dataIn : held_data) : '0;
    done           = send_phase && flushReady && last_word;
  end

endmodule
`default_nettype wire

// File: rtl/wti_snoop_controller.sv
`default_nettype none
// ============================================================================
// wti_snoop_controller: snoops foreign bus transactions, flushes/updates lines.
// Revision: 1.0
// ============================================================================
module wti_snoop_controller
  import states::*;
  import snoop_bus::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int INDEX_WIDTH   = 4,
  parameter int OFFSET_WIDTH  = 2,
  parameter int DATA_WIDTH    = 32,
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                busValid,
  input  logic                                busIsOwn,
  input  logic [1:0]                          busCommand,
  input  logic [ADDRESS_WIDTH-1:0]            busAddress,
  output logic                                snoopDone,
  output logic                                snoopHit,
  output logic                                snoopFlushed,
  output logic                                tagReadEnable,
  output logic [INDEX_WIDTH-1:0]              tagIndex,
  input  logic [TAG_WIDTH-1:0]                tagIn,
  input  logic [1:0]                          stateRead,
  output logic                                stateWriteEnable,
  output logic [1:0]                          stateWrite,
  output logic                                dataReadEnable,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0]               dataIn,
  output logic                                flushValid,
  output logic [ADDRESS_WIDTH-1:0]            flushAddress,
  output logic [DATA_WIDTH-1:0]               flushData,
  input  logic                                flushReady
);

  snoop_state_t         state, next_state;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  bus_cmd_t             cmd_q;
  logic                 hit_q, flushed_q;
  line_state_t          new_state_q;
  logic [TAG_WIDTH-1:0] bus_tag;
  logic [INDEX_WIDTH-1:0] bus_index;
  logic                 lookup_hit, tag_read, flush_start, flush_done;

  assign bus_tag    = TAG_WIDTH'(addr_tag(64'(busAddress), OFFSET_WIDTH, INDEX_WIDTH));
  assign bus_index  = INDEX_WIDTH'(addr_index(64'(busAddress), OFFSET_WIDTH, INDEX_WIDTH));
  assign lookup_hit = (stateRead != INVALID) && (tagIn == tag_q);
  // Gated by reset so a bus request held across reset cannot leak a read strobe.
  assign tag_read   = (state == IDLE) && busValid && !busIsOwn && !reset;
  assign flush_start = (state == LOOKUP) && (next_state == FLUSH_READ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state       = state;
    tagReadEnable    = tag_read;
    tagIndex         = (state == IDLE) ? (tag_read ? bus_index : '0) : index_q;
    stateWriteEnable = (state == UPDATE);
    stateWrite       = (state == UPDATE) ? new_state_q : INVALID;
    snoopDone        = (state == RESPOND);
    snoopHit         = (state == RESPOND) && hit_q;
    snoopFlushed     = (state == RESPOND) && flushed_q;
    case (state)
      IDLE:       if (busValid) next_state = busIsOwn ? RESPOND : LOOKUP;
      LOOKUP: begin
        if (!lookup_hit)                next_state = RESPOND;
        else if (stateRead == DIRTY)    next_state = FLUSH_READ;
        else if (cmd_q == BUS_READ)     next_state = RESPOND;
        else                            next_state = UPDATE;
      end
      FLUSH_READ: next_state = FLUSH_SEND;
      FLUSH_SEND: begin
        if (flush_done)      next_state = UPDATE;
        else if (flushReady) next_state = FLUSH_READ;
      end
      UPDATE:     next_state = RESPOND;
      RESPOND:    next_state = RELEASE;
      RELEASE:    if (!busValid) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q       <= '0;
      index_q     <= '0;
      cmd_q       <= BUS_READ;
      hit_q       <= 1'b0;
      flushed_q   <= 1'b0;
      new_state_q <= INVALID;
    end else if (state == IDLE && busValid) begin
      tag_q     <= bus_tag;
      index_q   <= bus_index;
      cmd_q     <= bus_cmd_t'(busCommand);
      hit_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else if (state == LOOKUP) begin
      hit_q       <= lookup_hit;
      flushed_q   <= lookup_hit && (stateRead == DIRTY);
      // A flushed line stays readable by us only if the foreign access was a read.
      new_state_q <= (lookup_hit && stateRead == DIRTY && cmd_q == BUS_READ) ? VALID : INVALID;
    end
  end

  wti_flush_unit #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .INDEX_WIDTH   (INDEX_WIDTH),
    .OFFSET_WIDTH  (OFFSET_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_flush (
    .clock          (clock),
    .reset          (reset),
    .start          (flush_start),
    .read_phase     (state == FLUSH_READ),
    .send_phase     (state == FLUSH_SEND),
    .tag            (tag_q),
    .index          (index_q),
    .dataIn         (dataIn),
    .flushReady     (flushReady),
    .dataReadEnable (dataReadEnable),
    .dataAddress    (dataAddress),
    .flushValid     (flushValid),
    .flushAddress   (flushAddress),
    .flushData      (flushData),
    .done           (flush_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_wti_snoop_controller.sv
`default_nettype none
// ============================================================================
// tb_wti_snoop_controller: scoreboard bench with a small tag/state/data RAM model.
// Revision: 1.0
// ============================================================================
module tb_wti_snoop_controller;
  import states::*;
  import snoop_bus::*;

  localparam int AW = 16, IW = 4, OW = 2, DW = 32, TW = AW - IW - OW, WORDS = 4;
  // 0xA8C0 splits as tag 0x2A3 | index 0 | word 0 in the 10|4|2 layout.
  localparam logic [AW-1:0] ADDR     = 16'hA8C0;
  localparam logic [TW-1:0] LINE_TAG = 10'h2A3;
  localparam logic [IW-1:0] LINE_IDX = 4'd0;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } flush_t;
  typedef struct packed { logic [IW-1:0] idx; logic [1:0] st; } wr_t;
  typedef struct packed { logic hit; logic flushed; } resp_t;

  logic clock = 1'b0, reset = 1'b1;
  logic busValid = 1'b0, busIsOwn = 1'b0, flushReady = 1'b0;
  logic [1:0] busCommand = 2'd0;
  logic [AW-1:0] busAddress = '0;
  logic snoopDone, snoopHit, snoopFlushed, tagReadEnable, stateWriteEnable;
  logic dataReadEnable, flushValid;
  logic [IW-1:0] tagIndex;
  logic [TW-1:0] tagIn = '0;
  logic [1:0] stateRead = 2'd0, stateWrite;
  logic [IW+OW-1:0] dataAddress;
  logic [DW-1:0] dataIn = '0, flushData;
  logic [AW-1:0] flushAddress;

  wti_snoop_controller dut (
    .clock(clock), .reset(reset), .busValid(busValid), .busIsOwn(busIsOwn),
    .busCommand(busCommand), .busAddress(busAddress), .snoopDone(snoopDone),
    .snoopHit(snoopHit), .snoopFlushed(snoopFlushed), .tagReadEnable(tagReadEnable),
    .tagIndex(tagIndex), .tagIn(tagIn), .stateRead(stateRead),
    .stateWriteEnable(stateWriteEnable), .stateWrite(stateWrite),
    .dataReadEnable(dataReadEnable), .dataAddress(dataAddress), .dataIn(dataIn),
    .flushValid(flushValid), .flushAddress(flushAddress), .flushData(flushData),
    .flushReady(flushReady)
  );

  always #5 clock = ~clock;

  logic [4+IW+1+2+1+IW+OW+1+AW+DW-1:0] all_outs;
  assign all_outs = {snoopDone, snoopHit, snoopFlushed, tagReadEnable, tagIndex,
                     stateWriteEnable, stateWrite, dataReadEnable, dataAddress,
                     flushValid, flushAddress, flushData};

  int checks = 0, errors = 0;
  flush_t exp_flush[$];
  wr_t    exp_wr[$];
  resp_t  exp_resp[$];
  int stall_word = -1, stall_left = 0, word_idx = 0, hs_count = 0;

  // Cache RAM model: synchronous reads, backdoor preload port for the bench.
  logic [TW-1:0] tags [16];
  logic [1:0]    st   [16];
  logic bd_en = 1'b0;
  logic [IW-1:0] bd_idx = '0;
  logic [TW-1:0] bd_tag = '0;
  logic [1:0]    bd_st = 2'd0;

  always @(posedge clock) begin
    if (bd_en) begin
      tags[bd_idx] <= bd_tag;
      st[bd_idx]   <= bd_st;
    end
    if (tagReadEnable) begin
      tagIn     <= tags[tagIndex];
      stateRead <= st[tagIndex];
    end
    if (stateWriteEnable) st[tagIndex] <= stateWrite;
    if (dataReadEnable)
      dataIn <= (dataAddress[IW+OW-1:OW] == LINE_IDX) ?
                DW'(8'h11 * (8'(dataAddress[OW-1:0]) + 8'd1)) : 32'hDEAD_BEEF;
  end

  // Scoreboard monitor: compares each DUT output event against the queued expectations.
  wr_t w_exp;
  resp_t r_exp;
  always @(negedge clock) begin
    if (stateWriteEnable) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL state_write: got idx=%0d st=%0d, required no write", tagIndex, stateWrite);
      end else begin
        w_exp = exp_wr.pop_front();
        if ({tagIndex, stateWrite} !== {w_exp.idx, w_exp.st}) begin
          errors++;
          $display("FAIL state_write: got idx=%0d st=%0d, required idx=%0d st=%0d",
                   tagIndex, stateWrite, w_exp.idx, w_exp.st);
        end
      end
    end
    if (flushValid) begin
      checks++;
      if (exp_flush.size() == 0) begin
        errors++;
        $display("FAIL flush_word: got addr=%h data=%h, required no flush", flushAddress, flushData);
      end else if ({flushAddress, flushData} !== {exp_flush[0].addr, exp_flush[0].data}) begin
        errors++;
        $display("FAIL flush_word: got addr=%h data=%h, required addr=%h data=%h",
                 flushAddress, flushData, exp_flush[0].addr, exp_flush[0].data);
      end
      if (word_idx == stall_word && stall_left > 0) begin
        flushReady = 1'b0;
        stall_left--;
      end else begin
        flushReady = 1'b1;
        if (exp_flush.size() != 0) void'(exp_flush.pop_front());
        word_idx++;
        hs_count++;
      end
    end else begin
      flushReady = 1'b0;
    end
    if (snoopDone) begin
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL snoop_done: unexpected pulse hit=%b flushed=%b", snoopHit, snoopFlushed);
      end else begin
        r_exp = exp_resp.pop_front();
        if ({snoopHit, snoopFlushed} !== {r_exp.hit, r_exp.flushed}) begin
          errors++;
          $display("FAIL snoop_resp: got hit=%b flushed=%b, required hit=%b flushed=%b",
                   snoopHit, snoopFlushed, r_exp.hit, r_exp.flushed);
        end
      end
    end
  end

  task automatic preload(input logic [IW-1:0] idx, input logic [TW-1:0] tg, input logic [1:0] s);
    @(negedge clock);
    bd_idx = idx; bd_tag = tg; bd_st = s; bd_en = 1'b1;
    @(negedge clock);
    bd_en = 1'b0;
  endtask

  task automatic drive_txn(input bus_cmd_t cmd, input logic own);
    @(negedge clock);
    word_idx = 0; hs_count = 0;
    busCommand = cmd; busAddress = ADDR; busIsOwn = own; busValid = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      // Scramble the bus to show the latched copies are used.
      busAddress = 16'h1234; busCommand = 2'd1;
      if (snoopDone) begin lat = i; return; end
    end
    lat = -1;
  endtask

  task automatic end_txn();
    @(negedge clock);
    busValid = 1'b0; busIsOwn = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic push_flush_words();
    for (int w = 0; w < WORDS; w++)
      exp_flush.push_back('{addr: ADDR + AW'(w), data: DW'(8'h11 * (w + 1))});
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_outs); end
    for (int i = 0; i < 16; i++) preload(4'(i), '0, INVALID);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_outs); end
  endtask

  task automatic test_valid_invalidate();
    int lat;
    preload(LINE_IDX, LINE_TAG, VALID);
    exp_resp.push_back('{hit: 1'b1, flushed: 1'b0});
    exp_wr.push_back('{idx: LINE_IDX, st: INVALID});
    drive_txn(BUS_INVALIDATE, 1'b0);
    #1;
    checks++;
    if ({tagReadEnable, tagIndex} !== {1'b1, LINE_IDX}) begin
      errors++; $display("FAIL lookup_strobe: got en=%b idx=%0d required en=1 idx=%0d", tagReadEnable, tagIndex, LINE_IDX);
    end
    wait_done(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency_invalidate: got %0d required 3", lat); end
    end_txn();
    checks++;
    if (st[LINE_IDX] !== INVALID || exp_wr.size() != 0) begin
      errors++; $display("FAIL invalidate_state: got %0d pending=%0d required 0 pending=0", st[LINE_IDX], exp_wr.size());
    end
  endtask

  task automatic test_valid_read();
    int lat;
    preload(LINE_IDX, LINE_TAG, VALID);
    exp_resp.push_back('{hit: 1'b1, flushed: 1'b0});
    drive_txn(BUS_READ, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL latency_read_valid: got %0d required 2", lat); end
    end_txn();
    checks++;
    if (st[LINE_IDX] !== VALID) begin errors++; $display("FAIL read_valid_state: got %0d required 1", st[LINE_IDX]); end
  endtask

  task automatic test_dirty_flush();
    int lat;
    preload(LINE_IDX, LINE_TAG, DIRTY);
    stall_word = 1; stall_left = 2;
    push_flush_words();
    exp_wr.push_back('{idx: LINE_IDX, st: VALID});
    exp_resp.push_back('{hit: 1'b1, flushed: 1'b1});
    drive_txn(BUS_READ, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 3 + 2 * WORDS + 2) begin errors++; $display("FAIL latency_flush: got %0d required %0d", lat, 3 + 2 * WORDS + 2); end
    end_txn();
    stall_word = -1;
    checks++;
    if (exp_flush.size() != 0 || exp_wr.size() != 0 || st[LINE_IDX] !== VALID) begin
      errors++; $display("FAIL flush_complete: pending=%0d/%0d state=%0d required 0/0 state=1",
                         exp_flush.size(), exp_wr.size(), st[LINE_IDX]);
    end
  endtask

  task automatic test_tag_miss();
    int lat;
    preload(LINE_IDX, 10'h015, VALID);
    exp_resp.push_back('{hit: 1'b0, flushed: 1'b0});
    drive_txn(BUS_WRITE, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL latency_miss: got %0d required 2", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({tagReadEnable, snoopDone} !== 2'b00) begin
        errors++; $display("FAIL release_hold: got tre=%b done=%b required 0 0", tagReadEnable, snoopDone);
      end
    end
    end_txn();
  endtask

  task automatic test_own();
    int lat;
    preload(LINE_IDX, LINE_TAG, DIRTY);
    exp_resp.push_back('{hit: 1'b0, flushed: 1'b0});
    drive_txn(BUS_WRITE, 1'b1);
    #1;
    checks++;
    if (tagReadEnable !== 1'b0) begin errors++; $display("FAIL own_lookup: got %b required 0", tagReadEnable); end
    wait_done(lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL latency_own: got %0d required 1", lat); end
    end_txn();
  endtask

  task automatic test_reset_mid_flush();
    int lat;
    int n;
    push_flush_words();
    drive_txn(BUS_READ, 1'b0);
    n = 0;
    while (hs_count < 2 && n < 100) begin @(posedge clock); #1; n++; end
    reset = 1'b1;
    #1;
    checks++;
    if (n >= 100 || all_outs !== '0) begin
      errors++; $display("FAIL reset_abort: got outs=%h waited=%0d required 0", all_outs, n);
    end
    exp_flush.delete(); exp_wr.delete(); exp_resp.delete();
    @(negedge clock);
    busValid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (st[LINE_IDX] !== DIRTY) begin errors++; $display("FAIL abort_state: got %0d required 2", st[LINE_IDX]); end
    push_flush_words();
    exp_wr.push_back('{idx: LINE_IDX, st: VALID});
    exp_resp.push_back('{hit: 1'b1, flushed: 1'b1});
    drive_txn(BUS_READ, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 3 + 2 * WORDS) begin errors++; $display("FAIL latency_reflush: got %0d required %0d", lat, 3 + 2 * WORDS); end
    end_txn();
    checks++;
    if (exp_flush.size() != 0 || exp_wr.size() != 0 || st[LINE_IDX] !== VALID) begin
      errors++; $display("FAIL reflush_complete: pending=%0d/%0d state=%0d required 0/0 state=1",
                         exp_flush.size(), exp_wr.size(), st[LINE_IDX]);
    end
  endtask

  initial begin
    test_reset();
    test_valid_invalidate();
    test_valid_read();
    test_dirty_flush();
    test_tag_miss();
    test_own();
    preload(LINE_IDX, LINE_TAG, DIRTY);
    test_reset_mid_flush();
    checks++;
    if (exp_resp.size() != 0) begin errors++; $display("FAIL resp_queue: got %0d pending required 0", exp_resp.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
